// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle MIPS core: sequences fetch/decode/execute/
// memory/write-back cycles and drives every datapath enable, mux select and alu_case.
module multicycle_controller #(
  parameter bit WAIT_MEM = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_zext,
  output logic [1:0] pc_src,
  output logic [1:0] alu_case,
  output logic       inst_done,
  output logic       illegal_op
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEM_ADDR = 4'd2;
  localparam logic [3:0] MEM_RD   = 4'd3;
  localparam logic [3:0] MEM_WB   = 4'd4;
  localparam logic [3:0] MEM_WR   = 4'd5;
  localparam logic [3:0] R_EXEC   = 4'd6;
  localparam logic [3:0] R_WB     = 4'd7;
  localparam logic [3:0] BRANCH   = 4'd8;
  localparam logic [3:0] IMM_EXEC = 4'd9;
  localparam logic [3:0] IMM_WB   = 4'd10;
  localparam logic [3:0] JUMP     = 4'd11;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic [3:0] state_q, state_d;
  logic [5:0] op_q;
  logic       ready;

  assign ready = WAIT_MEM ? mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= opcode;
    end
  end

  // Outputs stay at their zero defaults whenever rst is low, regardless of state.
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    imm_zext   = 1'b0;
    pc_src     = 2'b00;
    alu_case   = 2'b00;
    inst_done  = 1'b0;
    illegal_op = 1'b0;
    if (rst) begin
      case (state_q)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          if (ready) begin
            pc_write = 1'b1;
            ir_write = 1'b1;
            state_d  = DECODE;
          end
        end
        DECODE: begin
          alu_src_b = 2'b11;
          case (opcode)
            OP_LW, OP_SW:     state_d = MEM_ADDR;
            OP_R:             state_d = R_EXEC;
            OP_BEQ, OP_BNE:   state_d = BRANCH;
            OP_ADDI, OP_ANDI: state_d = IMM_EXEC;
            OP_J:             state_d = JUMP;
            default: begin
              state_d    = FETCH;
              illegal_op = 1'b1;
              inst_done  = 1'b1;
            end
          endcase
        end
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          if (op_q == OP_LW)      state_d = MEM_RD;
          else if (op_q == OP_SW) state_d = MEM_WR;
          else                    state_d = FETCH;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          if (ready) state_d = MEM_WB;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          inst_done  = 1'b1;
          state_d    = FETCH;
        end
        MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          if (ready) begin
            inst_done = 1'b1;
            state_d   = FETCH;
          end
        end
        R_EXEC: begin
          alu_src_a = 1'b1;
          alu_case  = 2'b10;
          state_d   = R_WB;
        end
        R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          inst_done = 1'b1;
          state_d   = FETCH;
        end
        BRANCH: begin
          alu_src_a = 1'b1;
          alu_case  = 2'b01;
          pc_src    = 2'b01;
          inst_done = 1'b1;
          pc_write  = (op_q == OP_BNE) ? ~zero : zero;
          state_d   = FETCH;
        end
        IMM_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          if (op_q == OP_ANDI) begin
            alu_case = 2'b11;
            imm_zext = 1'b1;
          end
          state_d = IMM_WB;
        end
        IMM_WB: begin
          reg_write = 1'b1;
          inst_done = 1'b1;
          state_d   = FETCH;
        end
        JUMP: begin
          pc_write  = 1'b1;
          pc_src    = 2'b10;
          inst_done = 1'b1;
          state_d   = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class cycle by
// cycle and compares the full output vector against hand-built expected values.
module tb_multicycle_controller;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a, imm_zext, inst_done, illegal_op;
  logic [1:0] alu_src_b, pc_src, alu_case;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  multicycle_controller #(.WAIT_MEM(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .imm_zext   (imm_zext),
    .pc_src     (pc_src),
    .alu_case   (alu_case),
    .inst_done  (inst_done),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit order: pc_write i_or_d mem_read mem_write ir_write reg_dst mem_to_reg reg_write
  //            alu_src_a alu_src_b[1:0] imm_zext pc_src[1:0] alu_case[1:0] inst_done illegal_op
  logic [17:0] outs;
  assign outs = {pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                 reg_write, alu_src_a, alu_src_b, imm_zext, pc_src, alu_case,
                 inst_done, illegal_op};

  localparam logic [17:0] E_ZERO  = 18'b0;
  localparam logic [17:0] E_F_RDY = {1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_F_WT  = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_DEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,1'b0,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_DEC_X = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,1'b0,2'b00,2'b00,1'b1,1'b1};
  localparam logic [17:0] E_MADDR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_MRD   = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_MWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,1'b0};
  localparam logic [17:0] E_MWR   = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_MWR_D = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,1'b0};
  localparam logic [17:0] E_REX   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,2'b10,1'b0,1'b0};
  localparam logic [17:0] E_RWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,1'b0};
  localparam logic [17:0] E_BR_T  = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b01,2'b01,1'b1,1'b0};
  localparam logic [17:0] E_BR_N  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b01,2'b01,1'b1,1'b0};
  localparam logic [17:0] E_I_ADD = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_I_AND = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b1,2'b00,2'b11,1'b0,1'b0};
  localparam logic [17:0] E_IWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,1'b0};
  localparam logic [17:0] E_JMP   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b10,2'b00,1'b1,1'b0};

  // Inputs are applied just after a rising edge, checked mid-cycle, then the edge is taken.
  task automatic cyc(input string tag, input logic [17:0] exp,
                     input logic [5:0] op, input logic mr, input logic z);
    opcode    = op;
    mem_ready = mr;
    zero      = z;
    #2;
    n_checks++;
    assert (outs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%b expected=%b", tag, outs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    cyc("reset_hold",   E_ZERO,  6'b000000, 1'b1, 1'b0);
    rst = 1'b1;

    cyc("r_fetch",      E_F_RDY, 6'b101011, 1'b1, 1'b0);
    cyc("r_decode",     E_DEC,   6'b000000, 1'b1, 1'b0);
    cyc("r_exec",       E_REX,   6'b100011, 1'b0, 1'b0);
    cyc("r_wb",         E_RWB,   6'b100011, 1'b0, 1'b0);

    cyc("lw_fetch",     E_F_RDY, 6'b000000, 1'b1, 1'b0);
    cyc("lw_decode",    E_DEC,   6'b100011, 1'b1, 1'b0);
    cyc("lw_addr",      E_MADDR, 6'b100011, 1'b0, 1'b0);
    cyc("lw_rd_wait1",  E_MRD,   6'b100011, 1'b0, 1'b0);
    cyc("lw_rd_wait2",  E_MRD,   6'b100011, 1'b0, 1'b0);
    cyc("lw_rd_done",   E_MRD,   6'b100011, 1'b1, 1'b0);
    cyc("lw_wb",        E_MWB,   6'b100011, 1'b0, 1'b0);

    cyc("sw_fetch_wait",E_F_WT,  6'b000000, 1'b0, 1'b0);
    cyc("sw_fetch",     E_F_RDY, 6'b000000, 1'b1, 1'b0);
    cyc("sw_decode",    E_DEC,   6'b101011, 1'b0, 1'b0);
    cyc("sw_addr",      E_MADDR, 6'b000000, 1'b1, 1'b0);
    cyc("sw_wr_wait",   E_MWR,   6'b000000, 1'b0, 1'b0);
    cyc("sw_wr_done",   E_MWR_D, 6'b000000, 1'b1, 1'b0);

    cyc("beq1_fetch",   E_F_RDY, 6'b000000, 1'b1, 1'b0);
    cyc("beq1_decode",  E_DEC,   6'b000100, 1'b1, 1'b0);
    cyc("beq_taken",    E_BR_T,  6'b000101, 1'b1, 1'b1);
    cyc("beq0_fetch",   E_F_RDY, 6'b000000, 1'b1, 1'b0);
    cyc("beq0_decode",  E_DEC,   6'b000100, 1'b1, 1'b0);
    cyc("beq_not",      E_BR_N,  6'b000100, 1'b1, 1'b0);
    cyc("bne1_fetch",   E_F_RDY, 6'b000000, 1'b1, 1'b0);
    cyc("bne1_decode",  E_DEC,   6'b000101, 1'b1, 1'b0);
    cyc("bne_not",      E_BR_N,  6'b000100, 1'b1, 1'b1);
    cyc("bne0_fetch",   E_F_RDY, 6'b000000, 1'b1, 1'b0);
    cyc("bne0_decode",  E_DEC,   6'b000101, 1'b1, 1'b0);
    cyc("bne_taken",    E_BR_T,  6'b000101, 1'b1, 1'b0);

    cyc("andi_fetch",   E_F_RDY, 6'b000000, 1'b1, 1'b0);
    cyc("andi_decode",  E_DEC,   6'b001100, 1'b1, 1'b0);
    cyc("andi_exec",    E_I_AND, 6'b001000, 1'b1, 1'b0);
    cyc("andi_wb",      E_IWB,   6'b000000, 1'b1, 1'b0);
    cyc("addi_fetch",   E_F_RDY, 6'b000000, 1'b1, 1'b0);
    cyc("addi_decode",  E_DEC,   6'b001000, 1'b1, 1'b0);
    cyc("addi_exec",    E_I_ADD, 6'b001100, 1'b1, 1'b0);
    cyc("addi_wb",      E_IWB,   6'b111111, 1'b1, 1'b0);

    cyc("j_fetch",      E_F_RDY, 6'b000000, 1'b1, 1'b0);
    cyc("j_decode",     E_DEC,   6'b000010, 1'b1, 1'b0);
    cyc("j_jump",       E_JMP,   6'b000000, 1'b1, 1'b0);

    cyc("ill_fetch",    E_F_RDY, 6'b000000, 1'b1, 1'b0);
    cyc("ill_decode",   E_DEC_X, 6'b111111, 1'b1, 1'b0);
    cyc("ill_refetch",  E_F_WT,  6'b111111, 1'b0, 1'b0);
    cyc("ill_refetch2", E_F_RDY, 6'b000000, 1'b1, 1'b0);

    cyc("rst_decode",   E_DEC,   6'b000000, 1'b1, 1'b0);
    cyc("rst_exec",     E_REX,   6'b000000, 1'b1, 1'b0);
    rst = 1'b0;
    cyc("rst_mid1",     E_ZERO,  6'b000000, 1'b1, 1'b1);
    cyc("rst_mid2",     E_ZERO,  6'b100011, 1'b1, 1'b1);
    cyc("rst_mid3",     E_ZERO,  6'b101011, 1'b1, 1'b1);
    rst = 1'b1;
    cyc("post_rst_wait",E_F_WT,  6'b000000, 1'b0, 1'b0);
    cyc("post_rst_f",   E_F_RDY, 6'b000000, 1'b1, 1'b0);
    cyc("post_rst_dec", E_DEC,   6'b000010, 1'b1, 1'b0);
    cyc("post_rst_j",   E_JMP,   6'b000000, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
